// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and helpers for the instruction-memory boot loader
package boot_pkg;

  typedef enum logic [1:0] {LEN, DATA, DONE, ERR} boot_state_t;

  localparam int BYTES_PER_WORD = 4;

  // A program length is usable only if it is non-empty and fits in memory.
  function automatic logic len_ok(input logic [31:0] n, input logic [31:0] depth);
    return (n != 32'd0) && (n <= depth);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// rtl/imem_boot_loader_byte_word_assembler.sv - little-endian byte-to-word shift register
module byte_word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_ready,
  output logic [31:0] word,
  output logic [31:0] word_next
);

  // Bytes enter at the top and shift down, so the first byte ends up as bits [7:0].
  assign word_next  = {byte_data, word[31:8]};
  assign word_ready = byte_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_idx <= 2'd0;
      word     <= 32'd0;
    end else if (byte_en) begin
      byte_idx <= byte_idx + 2'd1;
      word     <= word_next;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a length-prefixed program into instruction memory, then releases the core
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  imem_boot_loader_if.slave bus,
  input  logic              reload,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  boot_state_t       state, next_state;
  logic [ADDR_W:0]   len_q;
  logic [TCNT_W-1:0] tcnt;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;

  logic              accept;
  logic              collecting;
  logic              count_en;
  logic              reload_ok;
  logic              timeout_hit;
  logic [1:0]        byte_idx;
  logic              word_ready;
  logic [31:0]       word;
  logic [31:0]       word_next;

  assign accept      = bus.byte_valid && ready_q;
  assign timeout_hit = count_en && !accept && (tcnt == TCNT_W'(TIMEOUT - 1));

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (!collecting),
    .byte_en    (accept),
    .byte_data  (bus.byte_data),
    .byte_idx   (byte_idx),
    .word_ready (word_ready),
    .word       (word),
    .word_next  (word_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LEN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LEN: begin
        if (timeout_hit)     next_state = ERR;
        else if (word_ready) next_state = len_ok(word_next, 32'(DEPTH)) ? DATA : ERR;
      end
      DATA: begin
        // Leave only after the final write has been on the bus for its cycle.
        if (timeout_hit)                      next_state = ERR;
        else if (we_q && word_count == len_q) next_state = DONE;
      end
      DONE, ERR: begin
        if (reload) next_state = LEN;
      end
      default: next_state = LEN;
    endcase
  end

  always_comb begin
    collecting = 1'b0;
    count_en   = 1'b0;
    core_rst   = 1'b1;
    load_done  = 1'b0;
    load_err   = 1'b0;
    reload_ok  = 1'b0;
    case (state)
      LEN: begin
        collecting = 1'b1;
        // An idle source is fine until the first length byte arrives.
        count_en   = (byte_idx != 2'd0);
      end
      DATA: begin
        collecting = 1'b1;
        count_en   = 1'b1;
      end
      DONE: begin
        core_rst  = 1'b0;
        load_done = 1'b1;
        reload_ok = reload;
      end
      ERR: begin
        load_err  = 1'b1;
        reload_ok = reload;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      word_count <= '0;
      len_q      <= '0;
      tcnt       <= '0;
    end else begin
      ready_q <= (next_state == LEN) || (next_state == DATA);
      we_q    <= (state == DATA) && word_ready;
      if (reload_ok) begin
        addr_q     <= '0;
        word_count <= '0;
        len_q      <= '0;
        tcnt       <= '0;
      end else begin
        if (state == DATA && word_ready) begin
          addr_q     <= word_count[ADDR_W-1:0];
          word_count <= word_count + 1'b1;
        end
        if (state == LEN && word_ready) len_q <= word_next[ADDR_W:0];
        if (accept)        tcnt <= '0;
        else if (count_en) tcnt <= tcnt + 1'b1;
      end
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = we_q ? word : 32'd0;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed bench for the boot loader
module tb_imem_boot_loader;

  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 1000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            reload = 1'b0;
  logic            core_rst;
  logic            load_done;
  logic            load_err;
  logic [ADDR_W:0] word_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fall_cyc = -1;
  logic prev_core_rst = 1'b1;

  int          wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .reload     (reload),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Capture every memory write and the moment the core leaves reset.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wa.push_back(int'(bus.imem_addr));
      wd.push_back(bus.imem_wdata);
      wc.push_back(cyc);
    end
    if (prev_core_rst && !core_rst) fall_cyc = cyc;
    prev_core_rst = core_rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
    fall_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.byte_valid = 1'b0;
    tick(gap);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    if (n >= 50) chk("byte_ready_wait", 32'(n), 32'd0);
    tick(1);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, max_gap));
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick(1);
    reload = 1'b0;
  endtask

  initial begin
    int bad;
    logic [31:0] w;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset values
    tick(2);
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    rst = 1'b0;

    // Normal two-word load, back-to-back bytes
    clear_log();
    send_word(32'd2, 0);
    send_word(32'h00500093, 0);
    send_word(32'h00A00113, 0);
    tick(3);
    chk("n1_writes", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("n1_addr0", 32'(wa[0]), 32'd0);
      chk("n1_data0", wd[0], 32'h00500093);
      chk("n1_addr1", 32'(wa[1]), 32'd1);
      chk("n1_data1", wd[1], 32'h00A00113);
      chk("n1_back_to_back", 32'(wc[1] - wc[0]), 32'd4);
      chk("n1_core_rst_fall", 32'(fall_cyc), 32'(wc[1] + 1));
    end
    chk("n1_load_done", 32'(load_done), 32'd1);
    chk("n1_core_rst", 32'(core_rst), 32'd0);
    chk("n1_word_count", 32'(word_count), 32'd2);
    chk("n1_byte_ready", 32'(bus.byte_ready), 32'd0);

    // Reload, one word with random gaps, ignored reload mid-DATA
    clear_log();
    pulse_reload();
    chk("rl_core_rst", 32'(core_rst), 32'd1);
    chk("rl_load_done", 32'(load_done), 32'd0);
    chk("rl_word_count", 32'(word_count), 32'd0);
    send_word(32'd1, 5);
    send_byte(8'hEF, $urandom_range(0, 5));
    send_byte(8'hBE, $urandom_range(0, 5));
    pulse_reload();
    chk("rl_data_reload_ignored", 32'(bus.byte_ready), 32'd1);
    send_byte(8'hAD, $urandom_range(0, 5));
    send_byte(8'hDE, $urandom_range(0, 5));
    tick(3);
    chk("rl_writes", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("rl_addr", 32'(wa[0]), 32'd0);
      chk("rl_data", wd[0], 32'hDEADBEEF);
    end
    chk("rl_load_done", 32'(load_done), 32'd1);
    chk("rl_word_count_end", 32'(word_count), 32'd1);

    // Zero length
    clear_log();
    pulse_reload();
    send_word(32'd0, 0);
    chk("z_load_err", 32'(load_err), 32'd1);
    chk("z_core_rst", 32'(core_rst), 32'd1);
    chk("z_byte_ready", 32'(bus.byte_ready), 32'd0);
    tick(3);
    chk("z_writes", 32'(wa.size()), 32'd0);

    // Oversize length
    pulse_reload();
    chk("ov_err_cleared", 32'(load_err), 32'd0);
    send_word(32'(DEPTH + 1), 0);
    chk("ov_load_err", 32'(load_err), 32'd1);
    tick(3);
    chk("ov_writes", 32'(wa.size()), 32'd0);

    // Full-depth load
    pulse_reload();
    send_word(32'(DEPTH), 0);
    for (int i = 0; i < DEPTH; i++) send_word(32'h0BAD0000 + 32'(i) * 32'h00010001, 0);
    tick(3);
    chk("full_writes", 32'(wa.size()), 32'(DEPTH));
    bad = 0;
    for (int i = 0; i < wa.size() && i < DEPTH; i++) begin
      w = 32'h0BAD0000 + 32'(i) * 32'h00010001;
      if (wa[i] != i || wd[i] !== w) bad++;
    end
    chk("full_contents", 32'(bad), 32'd0);
    if (wa.size() == DEPTH) chk("full_last_addr", 32'(wa[DEPTH-1]), 32'd255);
    chk("full_load_done", 32'(load_done), 32'd1);
    chk("full_word_count", 32'(word_count), 32'(DEPTH));

    // Timeout after two data bytes
    clear_log();
    pulse_reload();
    send_word(32'd1, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    tick(TIMEOUT - 1);
    chk("to_not_yet", 32'(load_err), 32'd0);
    tick(1);
    chk("to_load_err", 32'(load_err), 32'd1);
    chk("to_writes", 32'(wa.size()), 32'd0);

    // Gap of TIMEOUT-1 idle cycles is tolerated
    pulse_reload();
    send_word(32'd1, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, TIMEOUT - 1);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    tick(3);
    chk("gap_load_err", 32'(load_err), 32'd0);
    chk("gap_load_done", 32'(load_done), 32'd1);
    chk("gap_writes", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) chk("gap_data", wd[0], 32'hDDCCBBAA);

    // Reset after one data byte
    clear_log();
    pulse_reload();
    send_word(32'd1, 0);
    send_byte(8'h55, 0);
    rst = 1'b1;
    tick(1);
    chk("mr_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("mr_core_rst", 32'(core_rst), 32'd1);
    chk("mr_word_count", 32'(word_count), 32'd0);
    chk("mr_imem_we", 32'(bus.imem_we), 32'd0);
    rst = 1'b0;
    send_word(32'd1, 0);
    send_word(32'h12345678, 0);
    tick(3);
    chk("mr_writes", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("mr_addr", 32'(wa[0]), 32'd0);
      chk("mr_data", wd[0], 32'h12345678);
    end
    chk("mr_load_done", 32'(load_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
